// File: rtl/opb_regbank_pkg.sv
// Register map, control bit positions and offset decode shared by the OPB register bank.
package opb_regbank_pkg;

    localparam int         MAX_REGS    = 16;
    localparam logic [7:0] DATA_BASE   = 8'h00;
    localparam logic [7:0] CTRL_OFS    = 8'h40;
    localparam logic [7:0] STATUS_OFS  = 8'h44;
    localparam int         CTRL_SNAP   = 0;
    localparam int         CTRL_FREEZE = 1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_DATA,
        SEL_CTRL,
        SEL_STATUS
    } reg_sel_e;

    // Decodes a word offset (byte offset >> 2) inside the 256-byte window.
    function automatic reg_sel_e decode_offset(input logic [5:0] word, input int num_regs);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word[5:4] == DATA_BASE[7:6] && int'(word[3:0]) < num_regs)
            sel = SEL_DATA;
        else if (word == CTRL_OFS[7:2])
            sel = SEL_CTRL;
        else if (word == STATUS_OFS[7:2])
            sel = SEL_STATUS;
        return sel;
    endfunction

endpackage

// File: rtl/opb_slave_if.sv
// OPB slave front end: window decode, one-cycle acknowledge and registered, gated read data.
module opb_slave_if
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_OPB_AWIDTH-1:0] addr,
    input  logic                    select,
    input  logic                    rnw,
    input  logic [C_OPB_DWIDTH-1:0] rd_data,
    output logic                    rd_en,
    output logic                    wr_en,
    output logic [5:0]              word_ofs,
    output logic                    xfer_ack,
    output logic [C_OPB_DWIDTH-1:0] sl_dbus
);

    logic in_window;
    logic hit;
    logic armed;

    assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign hit       = select && in_window && armed && !xfer_ack;
    assign rd_en     = hit && rnw;
    assign wr_en     = hit && !rnw;
    assign word_ofs  = addr[7:2];

    // armed rises only after select has been seen low, so a transfer cut by reset is never acked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            xfer_ack <= 1'b0;
            sl_dbus  <= '0;
        end else begin
            if (!select)
                armed <= 1'b1;
            xfer_ack <= hit;
            sl_dbus  <= rd_en ? rd_data : '0;
        end
    end

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Bank of user->PPC read registers with snapshot, freeze and sticky update flags behind one OPB slave.
module opb_register_bank_simulink2ppc
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter int          C_REG_WIDTH  = 32,
    parameter int          C_SNAPSHOT   = 1
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]           OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]         OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]           OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]           Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    input  logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_in,
    input  logic [C_NUM_REGS-1:0]             user_valid
);

    if (C_NUM_REGS < 1 || C_NUM_REGS > MAX_REGS) begin : g_bad_num_regs
        $error("C_NUM_REGS out of range");
    end

    logic [C_OPB_AWIDTH-1:0]   addr;
    logic [C_OPB_DWIDTH-1:0]   wdata;
    logic [C_OPB_DWIDTH/8-1:0] be;
    logic [C_OPB_DWIDTH-1:0]   rd_data;
    logic [C_OPB_DWIDTH-1:0]   sl_dbus;
    logic                      rd_en;
    logic                      wr_en;
    logic [5:0]                word_ofs;
    reg_sel_e                  sel;

    logic [C_REG_WIDTH-1:0] shadow    [C_NUM_REGS];
    logic [C_REG_WIDTH-1:0] snap_bank [C_NUM_REGS];
    logic [C_REG_WIDTH-1:0] data_val;
    logic [C_NUM_REGS-1:0]  updated;
    logic [C_NUM_REGS-1:0]  load_acc;
    logic [C_NUM_REGS-1:0]  flag_clr;
    logic                   freeze;
    logic                   wr_ctrl;
    logic                   wr_status;
    logic                   snap_pulse;
    logic                   unused_bits;

    // be[0] is OPB_BE[3] and wdata[k] is OPB_DBus[31-k]: the bus is big-endian numbered
    assign addr        = OPB_ABus;
    assign wdata       = OPB_DBus;
    assign be          = OPB_BE;
    assign Sl_DBus     = sl_dbus;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign unused_bits = ^{OPB_seqAddr, be, wdata};

    assign sel        = decode_offset(word_ofs, C_NUM_REGS);
    assign wr_ctrl    = wr_en && (sel == SEL_CTRL) && be[0];
    assign wr_status  = wr_en && (sel == SEL_STATUS) && be[0];
    assign snap_pulse = wr_ctrl && wdata[CTRL_SNAP];

    opb_slave_if #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_OPB_DWIDTH (C_OPB_DWIDTH)
    ) u_slave_if (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .addr     (addr),
        .select   (OPB_select),
        .rnw      (OPB_RNW),
        .rd_data  (rd_data),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .word_ofs (word_ofs),
        .xfer_ack (Sl_xferAck),
        .sl_dbus  (sl_dbus)
    );

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            freeze <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++)
                shadow[i] <= '0;
        end else begin
            if (wr_ctrl)
                freeze <= wdata[CTRL_FREEZE];
            for (int i = 0; i < C_NUM_REGS; i++)
                if (load_acc[i])
                    shadow[i] <= user_data_in[i*C_REG_WIDTH +: C_REG_WIDTH];
        end
    end

    // Non-blocking copy: a load in the SNAP cycle reaches the shadow but not this snapshot
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int i = 0; i < C_NUM_REGS; i++)
                snap_bank[i] <= '0;
        end else if (snap_pulse) begin
            for (int i = 0; i < C_NUM_REGS; i++)
                snap_bank[i] <= shadow[i];
        end
    end

    always_comb begin
        load_acc = user_valid & {C_NUM_REGS{!freeze}};
        flag_clr = '0;
        if (wr_status)
            flag_clr = wdata[C_NUM_REGS-1:0];
        if (C_SNAPSHOT != 0 && snap_pulse)
            flag_clr = '1;
        if (C_SNAPSHOT == 0 && rd_en && sel == SEL_DATA) begin
            for (int i = 0; i < C_NUM_REGS; i++)
                if (word_ofs[3:0] == 4'(i))
                    flag_clr[i] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a same-cycle load always wins
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst)
            updated <= '0;
        else
            updated <= (updated & ~flag_clr) | load_acc;
    end

    always_comb begin
        data_val = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (word_ofs[3:0] == 4'(i))
                data_val = (C_SNAPSHOT != 0) ? snap_bank[i] : shadow[i];
        rd_data = '0;
        case (sel)
            SEL_DATA:   rd_data = C_OPB_DWIDTH'(data_val);
            SEL_CTRL:   rd_data[CTRL_FREEZE] = freeze;
            SEL_STATUS: rd_data = C_OPB_DWIDTH'(updated);
            default:    rd_data = '0;
        endcase
    end

endmodule
